// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-network psum collector.
//   PSUM_WIDTH_DEF / ACC_WIDTH_DEF : default beat and accumulator widths
//   pix_state_e                    : pixel FSM encoding (idle / accumulating)
//   clog2()                        : constant-foldable ceiling log2
//   sat_add()                      : unsigned add clamped to a given width, with overflow flag
package bnn_pkg;

  localparam int unsigned PSUM_WIDTH_DEF = 4;
  localparam int unsigned ACC_WIDTH_DEF  = 10;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } pix_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Returns {overflow, sum}; sum clamped to 2^width-1.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << width) - 33'd1;
    if (sum > max) return {1'b1, max[31:0]};
    return {1'b0, sum[31:0]};
  endfunction

endpackage

// File: rtl/bnn_bit_packer.sv
// Packs single activation bits LSB-first into words and presents them over valid/ready.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bit_valid       a pixel finished this cycle; bit_in is its activation
//   bit_in          activation bit
//   flush           request to emit a partial word at the next pixel boundary
//   pixel_open      a multi-beat pixel is in progress (no boundary unless it ends)
//   out_ready       downstream accepts
//   out_valid       out_data/out_count valid
//   out_data        packed bits, bit0 oldest, unused upper bits 0
//   out_count       number of valid bits in out_data
//   busy            bits pending or word held in output register
module bnn_bit_packer import bnn_pkg::*; #(
  parameter int unsigned PACK_WIDTH = 8,
  parameter int unsigned CNT_W      = clog2(PACK_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  input  logic                  flush,
  input  logic                  pixel_open,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [PACK_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      out_count,
  output logic                  busy
);

  logic [PACK_WIDTH-1:0] pack_q, pack_d, pack_after;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_after;
  logic                  flush_pend_q, flush_pend_d;
  logic                  out_valid_q, out_valid_d;
  logic [PACK_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]      out_count_q, out_count_d;
  logic                  pend, boundary, can_emit, flush_go, emit;

  always_comb begin
    pack_after = pack_q;
    cnt_after  = cnt_q;
    // A full word is always emitted at once, so cnt_q < PACK_WIDTH whenever a bit arrives.
    if (bit_valid) begin
      pack_after[cnt_q[CNT_W-2:0]] = bit_in;
      cnt_after                    = cnt_q + CNT_W'(1);
    end

    pend     = flush_pend_q | flush;
    boundary = bit_valid | ~pixel_open;
    can_emit = ~out_valid_q | out_ready;
    flush_go = can_emit & boundary & pend;
    emit     = can_emit & ((cnt_after == CNT_W'(PACK_WIDTH)) | (flush_go & (cnt_after != '0)));

    pack_d       = pack_after;
    cnt_d        = cnt_after;
    flush_pend_d = flush_go ? 1'b0 : pend;  // executed or dropped when nothing is packed
    out_valid_d  = out_valid_q & ~out_ready;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    if (emit) begin
      out_valid_d  = 1'b1;
      out_data_d   = pack_after;
      out_count_d  = cnt_after;
      pack_d       = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
    end else begin
      pack_q       <= pack_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign busy      = out_valid_q | (cnt_q != '0);

endmodule

// File: rtl/bnn_psum_collector.sv
// Collects popcount beats from an XNOR PE column, accumulates them per output pixel over
// input channels, thresholds to a binary activation and packs activations into words.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_num_ch      beats per pixel (0 treated as 1), sampled on the first beat of a pixel
//   cfg_threshold   activation = (sum >= threshold), sampled on the last beat
//   psum_valid/psum_ready/psum_in   beat input handshake
//   flush           emit partially packed word at the next pixel boundary
//   out_valid/out_ready/out_data/out_count   packed word output handshake
//   busy            pixel in progress, bits pending, or word held
//   err_overflow    sticky accumulator saturation flag
module bnn_psum_collector import bnn_pkg::*; #(
  parameter int unsigned PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned CH_CNT_W   = 6,
  parameter int unsigned PACK_WIDTH = 8,
  localparam int unsigned CNT_W     = clog2(PACK_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH_CNT_W-1:0]   cfg_num_ch,
  input  logic [ACC_WIDTH-1:0]  cfg_threshold,
  input  logic                  psum_valid,
  output logic                  psum_ready,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PACK_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      out_count,
  output logic                  busy,
  output logic                  err_overflow
);

  pix_state_e           state_q, state_d;
  logic [CH_CNT_W-1:0]  ch_cnt_q, ch_cnt_d;
  logic [CH_CNT_W-1:0]  num_ch_q, num_ch_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_next;
  logic                 err_q, err_d;
  logic [CH_CNT_W-1:0]  cfg_num_eff, num_ch_cur;
  logic [32:0]          sat_res;
  logic                 accept, last_beat, act_bit, packer_busy;
  logic                 unused_sat;

  assign psum_ready  = ~(out_valid & ~out_ready);
  assign accept      = psum_valid & psum_ready;
  assign cfg_num_eff = (cfg_num_ch == '0) ? CH_CNT_W'(1) : cfg_num_ch;
  // Channel count is live from config on the first beat, latched afterwards.
  assign num_ch_cur  = (state_q == StIdle) ? cfg_num_eff : num_ch_q;
  assign last_beat   = accept & (ch_cnt_q == num_ch_cur - CH_CNT_W'(1));

  assign sat_res    = sat_add(32'(acc_q), 32'(psum_in), ACC_WIDTH);
  assign acc_next   = sat_res[ACC_WIDTH-1:0];
  assign unused_sat = ^sat_res[31:ACC_WIDTH];
  assign act_bit    = acc_next >= cfg_threshold;

  always_comb begin
    state_d  = state_q;
    ch_cnt_d = ch_cnt_q;
    num_ch_d = num_ch_q;
    acc_d    = acc_q;
    err_d    = err_q | (accept & sat_res[32]);
    if (accept) begin
      if (state_q == StIdle) num_ch_d = cfg_num_eff;
      if (last_beat) begin
        state_d  = StIdle;
        ch_cnt_d = '0;
        acc_d    = '0;
      end else begin
        state_d  = StAccum;
        ch_cnt_d = ch_cnt_q + CH_CNT_W'(1);
        acc_d    = acc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ch_cnt_q <= '0;
      num_ch_q <= '0;
      acc_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
      num_ch_q <= num_ch_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
    end
  end

  bnn_bit_packer #(
    .PACK_WIDTH(PACK_WIDTH),
    .CNT_W     (CNT_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (last_beat),
    .bit_in    (act_bit),
    .flush     (flush),
    .pixel_open(state_q == StAccum),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (packer_busy)
  );

  assign busy         = (state_q == StAccum) | packer_busy;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_bnn_psum_collector.sv
module tb_bnn_psum_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] cfg_num_ch;
  logic [9:0] cfg_threshold;
  logic       psum_valid, psum_ready, flush, out_valid, out_ready, busy, err_overflow;
  logic [3:0] psum_in;
  logic [7:0] out_data;
  logic [3:0] out_count;

  // Second instance with a narrow accumulator so saturation is reachable.
  logic [5:0] cfg_num_ch8;
  logic [7:0] thr8;
  logic       pv8, pr8, fl8, ov8, busy8, err8;
  logic       ordy8 = 1'b1;
  logic [3:0] pin8;
  logic [7:0] od8;
  logic [3:0] oc8;

  always #5 clk = ~clk;

  bnn_psum_collector dut (
    .clk(clk), .rst(rst), .cfg_num_ch(cfg_num_ch), .cfg_threshold(cfg_threshold),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_in(psum_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .busy(busy), .err_overflow(err_overflow)
  );

  bnn_psum_collector #(.ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .cfg_num_ch(cfg_num_ch8), .cfg_threshold(thr8),
    .psum_valid(pv8), .psum_ready(pr8), .psum_in(pin8), .flush(fl8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_count(oc8),
    .busy(busy8), .err_overflow(err8)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected word per completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got data %0h count %0d expected none", out_data,
                 out_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_data", 32'(out_data), 32'(e.data));
        chk("word_count", 32'(out_count), 32'(e.count));
      end
    end
  end

  // Drives one beat and returns at posedge+1 of the accepting edge.
  task automatic beat(input logic [3:0] p);
    int n;
    n = 0;
    psum_valid = 1'b1;
    psum_in    = p;
    @(negedge clk);
    while (!psum_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!psum_ready) chk("beat_timeout", 32'(psum_ready), 32'd1);
    @(posedge clk);
    #1;
    psum_valid = 1'b0;
  endtask

  task automatic pixel3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    beat(a);
    beat(b);
    beat(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_num_ch = 6'd3; cfg_threshold = 10'd10; psum_valid = 1'b0; psum_in = '0;
    flush = 1'b0; out_ready = 1'b1;
    cfg_num_ch8 = 6'd63; thr8 = 8'd255; pv8 = 1'b0; pin8 = 4'd15; fl8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_overflow), 0);
    chk("rst_psum_ready", 32'(psum_ready), 1);

    // 8 pixels alternating 1/0 -> 0x55
    exp_q.push_back('{data: 8'h55, count: 4'd8});
    for (int i = 0; i < 4; i++) begin
      pixel3(4'd4, 4'd4, 4'd3);
      pixel3(4'd1, 4'd2, 4'd3);
      if (i == 3) chk("word_latency_valid", 32'(out_valid), 1);
      else chk("no_early_word", 32'(out_valid), 0);
    end
    tick();

    // num_ch=0 treated as 1; bits 1,0,1 then flush from idle
    cfg_num_ch = 6'd0; cfg_threshold = 10'd5;
    beat(4'd5); beat(4'd4); beat(4'd5);
    chk("no_word_before_flush", 32'(out_valid), 0);
    exp_q.push_back('{data: 8'h05, count: 4'd3});
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_idle_valid", 32'(out_valid), 1);
    tick();

    // Backpressure: all-ones word held while downstream stalls
    out_ready = 1'b0; cfg_num_ch = 6'd1; cfg_threshold = 10'd0;
    exp_q.push_back('{data: 8'hFF, count: 4'd8});
    for (int i = 0; i < 8; i++) beat(4'd0);
    cfg_threshold = 10'd1;
    psum_valid = 1'b1; psum_in = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_psum_ready", 32'(psum_ready), 0);
      chk("stall_out_data", 32'(out_data), 32'hFF);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 psum_valid = 1'b0;
    exp_q.push_back('{data: 8'hFE, count: 4'd8});
    for (int i = 0; i < 7; i++) beat(4'd1);
    tick();

    // flush mid-pixel waits for the last beat and includes its bit
    cfg_num_ch = 6'd3; cfg_threshold = 10'd10;
    beat(4'd4);
    flush = 1'b1; beat(4'd4); flush = 1'b0;
    chk("flush_mid_no_word", 32'(out_valid), 0);
    chk("flush_mid_busy", 32'(busy), 1);
    exp_q.push_back('{data: 8'h01, count: 4'd1});
    beat(4'd3);
    chk("flush_mid_valid", 32'(out_valid), 1);
    tick();

    // flush coincident with last beat
    cfg_num_ch = 6'd1; cfg_threshold = 10'd0;
    beat(4'd0); beat(4'd0);
    exp_q.push_back('{data: 8'h07, count: 4'd3});
    flush = 1'b1; beat(4'd0); flush = 1'b0;
    tick();

    // 63 x 15 = 945 fits in 10 bits: no overflow, 945 >= 945
    cfg_num_ch = 6'd63; cfg_threshold = 10'd945;
    exp_q.push_back('{data: 8'h01, count: 4'd1});
    for (int i = 0; i < 63; i++) begin
      if (i == 62) flush = 1'b1;
      beat(4'd15);
    end
    flush = 1'b0;
    chk("no_overflow_10b", 32'(err_overflow), 0);
    tick();

    // Reset mid-word (pack_cnt=5) and mid-pixel (ch_cnt=1)
    cfg_num_ch = 6'd3; cfg_threshold = 10'd10;
    for (int i = 0; i < 5; i++) pixel3(4'd4, 4'd4, 4'd3);
    beat(4'd4);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_out_count", 32'(out_count), 0);
    chk("midrst_busy", 32'(busy), 0);
    cfg_num_ch = 6'd1; cfg_threshold = 10'd0;
    exp_q.push_back('{data: 8'h01, count: 4'd1});
    flush = 1'b1; beat(4'd0); flush = 1'b0;
    tick();

    // 8-bit accumulator saturates at 255; err sticky
    chk("sat_err_before", 32'(err8), 0);
    pv8 = 1'b1; fl8 = 1'b1;
    repeat (63) @(posedge clk);
    #1 pv8 = 1'b0; fl8 = 1'b0;
    chk("sat_err_set", 32'(err8), 1);
    chk("sat_word_valid", 32'(ov8), 1);
    chk("sat_word_data", 32'(od8), 32'h01);
    chk("sat_word_count", 32'(oc8), 1);
    cfg_num_ch8 = 6'd1; pin8 = 4'd0; pv8 = 1'b1; tick(); pv8 = 1'b0;
    tick();
    chk("sat_err_sticky", 32'(err8), 1);

    repeat (5) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
